// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helper functions for the VGA timing generator.
// Holds the default 640x480@60 set, an 800x600@60 set and sync polarity names.
// Helpers derive axis totals and the first active position from porch/sync widths.
package vga_timing_pkg;

    localparam int SYNC_ACTIVE_LOW  = 0;
    localparam int SYNC_ACTIVE_HIGH = 1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_LEAD     = 2;
    localparam int DEF_CW       = 10;

    // 800x600 @ 60 Hz, 40 MHz pixel clock (positive syncs)
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FRONT  = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BACK   = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FRONT  = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BACK   = 23;

    function automatic int axis_total(int sync, int back, int active, int front);
        return sync + back + active + front;
    endfunction

    function automatic int h_total(int sync, int back, int active, int front);
        return axis_total(sync, back, active, front);
    endfunction

    function automatic int v_total(int sync, int back, int active, int front);
        return axis_total(sync, back, active, front);
    endfunction

    // Regions run sync, back porch, active, front porch, so active starts here.
    function automatic int active_start(int sync, int back);
        return sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Bundle of timing outputs produced by vga_timing_gen.
// master: the generator drives everything; slave: DAC / sprite pipeline reads it.
// Pure output bus, no backpressure.
interface vga_timing_if #(parameter int CW = vga_timing_pkg::DEF_CW);
    logic          pix_en;
    logic [CW-1:0] hcount_out;
    logic [CW-1:0] vcount_out;
    logic          hsync;
    logic          vsync;
    logic          display_en;
    logic          vga_blank_n;
    logic [CW-1:0] xcoord;
    logic [CW-1:0] ycoord;
    logic          fetch_en;
    logic [CW-1:0] fetch_x;
    logic [CW-1:0] fetch_y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_en, hcount_out, vcount_out, hsync, vsync, display_en,
               vga_blank_n, xcoord, ycoord, fetch_en, fetch_x, fetch_y,
               line_start, frame_start
    );

    modport slave (
        input  pix_en, hcount_out, vcount_out, hsync, vsync, display_en,
               vga_blank_n, xcoord, ycoord, fetch_en, fetch_x, fetch_y,
               line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus region decodes of its next value.
// Ports: clk/reset, en (advance); count (registered), wrap (comb, this edge wraps),
// in_sync/in_active/coord and in_fetch/fetch_coord (comb, for the post-edge position).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int LEAD   = 0,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          in_sync,
    output logic          in_active,
    output logic [CW-1:0] coord,
    output logic          in_fetch,
    output logic [CW-1:0] fetch_coord
);
    localparam int TOTAL = axis_total(SYNC, BACK, ACTIVE, FRONT);
    localparam int START = active_start(SYNC, BACK);

    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
    // Range limits kept one bit wider so the look-ahead sum cannot alias.
    localparam logic [CW:0]   ACT_LO   = (CW+1)'(START);
    localparam logic [CW:0]   ACT_HI   = (CW+1)'(START + ACTIVE);
    localparam logic [CW:0]   LOOK     = (CW+1)'(LEAD);

    logic [CW-1:0] count_next;
    logic [CW:0]   pos_ext;
    logic [CW:0]   look_pos;
    logic [CW:0]   act_off;
    logic [CW:0]   look_off;

    always_comb begin
        wrap       = en && (count == LAST);
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + 1'b1;
        end

        // Decodes describe the position the counter holds after this edge,
        // so registered outputs line up with the registered count.
        pos_ext   = {1'b0, count_next};
        look_pos  = pos_ext + LOOK;
        act_off   = pos_ext - ACT_LO;
        look_off  = look_pos - ACT_LO;

        in_sync   = (count_next < SYNC_END);
        in_active = (pos_ext >= ACT_LO) && (pos_ext < ACT_HI);
        coord     = in_active ? act_off[CW-1:0] : '0;
        // Look-ahead never wraps into the next line: positions past the end
        // simply fall outside the active window.
        in_fetch    = (look_pos >= ACT_LO) && (look_pos < ACT_HI);
        fetch_coord = in_fetch ? look_off[CW-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= LAST;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/blank/coordinate generator with pixel-enable divider,
// line/frame strobes and a LEAD-pixel look-ahead fetch port (all outputs registered).
// Ports: clk, reset (sync, active-high), vid (vga_timing_if master) carrying all outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter int VSYNC_POL = SYNC_ACTIVE_LOW,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int LEAD      = DEF_LEAD,
    parameter int CW        = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    vga_timing_if.master  vid
);
    localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

    localparam logic       HS_ON    = (HSYNC_POL != 0);
    localparam logic       VS_ON    = (VSYNC_POL != 0);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_err_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (LEAD < 0 || LEAD >= H_SYNC + H_BACK) begin : g_err_lead
        $error("vga_timing_gen: LEAD must be below H_SYNC+H_BACK");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_err_div
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end

    logic [3:0]    div;
    logic [3:0]    div_next;
    logic          tick;

    logic [CW-1:0] h_count, v_count;
    logic          h_wrap, v_wrap;
    logic          h_sync, v_sync;
    logic          h_act, v_act;
    logic [CW-1:0] h_coord, v_coord;
    logic          h_fetch, v_fetch;
    logic [CW-1:0] h_fetch_coord, v_fetch_coord;

    // tick marks the clk whose edge advances the pixel position; pix_en is its
    // registered twin, held low for the first cycle out of reset.
    always_comb begin
        tick     = (div == DIV_LAST);
        div_next = tick ? 4'd0 : div + 4'd1;
    end

    vga_axis_counter #(
        .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT),
        .LEAD(LEAD), .CW(CW)
    ) u_h (
        .clk(clk), .reset(reset), .en(tick),
        .count(h_count), .wrap(h_wrap), .in_sync(h_sync),
        .in_active(h_act), .coord(h_coord),
        .in_fetch(h_fetch), .fetch_coord(h_fetch_coord)
    );

    // Vertical axis advances once per horizontal wrap; look-ahead is
    // horizontal only, so its fetch decode equals its active decode.
    vga_axis_counter #(
        .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT),
        .LEAD(0), .CW(CW)
    ) u_v (
        .clk(clk), .reset(reset), .en(h_wrap),
        .count(v_count), .wrap(v_wrap), .in_sync(v_sync),
        .in_active(v_act), .coord(v_coord),
        .in_fetch(v_fetch), .fetch_coord(v_fetch_coord)
    );

    assign vid.hcount_out = h_count;
    assign vid.vcount_out = v_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            div             <= 4'd0;
            vid.pix_en      <= 1'b0;
            vid.hsync       <= ~HS_ON;
            vid.vsync       <= ~VS_ON;
            vid.display_en  <= 1'b0;
            vid.vga_blank_n <= 1'b0;
            vid.xcoord      <= '0;
            vid.ycoord      <= '0;
            vid.fetch_en    <= 1'b0;
            vid.fetch_x     <= '0;
            vid.fetch_y     <= '0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else begin
            div             <= div_next;
            vid.pix_en      <= (div_next == DIV_LAST);
            vid.hsync       <= h_sync ? HS_ON : ~HS_ON;
            vid.vsync       <= v_sync ? VS_ON : ~VS_ON;
            vid.display_en  <= h_act & v_act;
            vid.vga_blank_n <= h_act & v_act;
            vid.xcoord      <= (h_act & v_act) ? h_coord : '0;
            vid.ycoord      <= (h_act & v_act) ? v_coord : '0;
            vid.fetch_en    <= h_fetch & v_fetch;
            vid.fetch_x     <= (h_fetch & v_fetch) ? h_fetch_coord : '0;
            vid.fetch_y     <= (h_fetch & v_fetch) ? v_fetch_coord : '0;
            // Wraps are single-clk events even when CLK_DIV > 1.
            vid.line_start  <= h_wrap;
            vid.frame_start <= h_wrap & v_wrap;
        end
    end

endmodule
